// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the front-end redirect path: FSM state encoding,
// jump-target alignment mask and the default flush depth that the
// fetch/decode flush logic also uses.
package branch_redirect_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    RESUME   = 2'd3
  } redirect_state_e;

  // Low target bits that must be zero for a legal instruction address.
  localparam logic [1:0] JUMP_ALIGN_MASK = 2'b11;

  // Number of cycles the younger IF/ID stages are flushed after a jump.
  localparam int FLUSH_CYCLES_DEFAULT = 2;

  // Flush counter width; covers the legal FLUSH_CYCLES range 1..15.
  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/redirect_flush_counter.sv
// Loadable down-counter with a zero flag. Holds at zero instead of wrapping,
// so an extra decrement request can never re-arm a flush.
module redirect_flush_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; async clear on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: consumes execute's jump result, stalls execute,
// flushes IF/ID for FLUSH_CYCLES cycles, then hands the jump target to
// fetch over a valid/ready handshake.
//
// state    | meaning
// IDLE     | waiting for execute_done && jump_signal
// FLUSH    | flush_if/flush_id high, execute stalled, counter running
// REDIRECT | redirect_valid high until fetch_ready (or fault pulse)
// RESUME   | one cycle with execute released; inputs ignored
//
// Optional build macro REDIRECT_ALIGN_CHECK_EN adds misalign_fault/fault_pc:
// a misaligned target is flushed as usual but reported as a one-cycle fault
// instead of being redirected.
module branch_redirect_unit
  import branch_redirect_unit_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              execute_done,
  input  logic              jump_signal,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic              fetch_ready,
  output logic              stall_execute,
  output logic              flush_if,
  output logic              flush_id,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  redirect_count
`ifdef REDIRECT_ALIGN_CHECK_EN
  ,
  output logic              misalign_fault,
  output logic [ADDR_W-1:0] fault_pc
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  redirect_state_e        state;
  redirect_state_e        state_next;
  logic                   capture;
  logic                   handshake;
  logic                   flush_zero;
  logic [FLUSH_CNT_W-1:0] flush_count;
  logic                   misalign_q;

  // Only an IDLE cycle can accept a jump; later cycles of the same
  // instruction are ignored.
  assign capture   = (state == IDLE) && execute_done && jump_signal;
  assign handshake = redirect_valid && fetch_ready;

  redirect_flush_counter #(
    .W (FLUSH_CNT_W)
  ) u_flush_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (capture),
    .load_value (FLUSH_LOAD),
    .dec        (state == FLUSH),
    .count      (flush_count),
    .zero       (flush_zero)
  );

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (capture) state_next = FLUSH;
      FLUSH:    if (flush_zero) state_next = REDIRECT;
      REDIRECT: if (misalign_q || handshake) state_next = RESUME;
      RESUME:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State-only decodes; no input reaches these outputs combinationally.
  assign stall_execute = (state == FLUSH) || (state == REDIRECT);
  assign busy          = (state != IDLE);

  // State register and registered outputs, pre-decoded from next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_count <= '0;
    end else begin
      state          <= state_next;
      flush_if       <= (state_next == FLUSH);
      flush_id       <= (state_next == FLUSH);
      redirect_valid <= (state_next == REDIRECT) && !misalign_q;
      if (capture) begin
        redirect_pc <= jump_target;
      end
      if (handshake) begin
        redirect_count <= redirect_count + CNT_W'(1);
      end
    end
  end

`ifdef REDIRECT_ALIGN_CHECK_EN
  logic [ADDR_W-1:0] branch_pc_q;

  // Latch the jump's own PC and alignment status; report one fault pulse
  // when the flush finishes for a misaligned target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_pc_q    <= '0;
      misalign_q     <= 1'b0;
      misalign_fault <= 1'b0;
      fault_pc       <= '0;
    end else begin
      if (capture) begin
        branch_pc_q <= branch_pc;
        misalign_q  <= |(jump_target[1:0] & JUMP_ALIGN_MASK);
      end
      misalign_fault <= (state_next == REDIRECT) && misalign_q;
      if ((state_next == REDIRECT) && misalign_q) begin
        fault_pc <= branch_pc_q;
      end
    end
  end
`else
  // Without the alignment check the jump's own PC has no consumer.
  logic unused_branch_pc;
  assign unused_branch_pc = ^branch_pc;
  assign misalign_q       = 1'b0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: each issued jump pushes its
// expected redirect into a queue; a negedge monitor pops and compares on
// every redirect handshake. Directed checks cover flush timing, stall and
// busy decode, backpressure, stale inputs and asynchronous reset.
module tb_branch_redirect_unit;

  localparam int AW = 64;
  localparam int FC = 2;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          execute_done;
  logic          jump_signal;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] branch_pc;
  logic          fetch_ready;
  logic          stall_execute;
  logic          flush_if;
  logic          flush_id;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          busy;
  logic [CW-1:0] redirect_count;
`ifdef REDIRECT_ALIGN_CHECK_EN
  logic          misalign_fault;
  logic [AW-1:0] fault_pc;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  branch_redirect_unit #(
    .ADDR_W       (AW),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .execute_done   (execute_done),
    .jump_signal    (jump_signal),
    .jump_target    (jump_target),
    .branch_pc      (branch_pc),
    .fetch_ready    (fetch_ready),
    .stall_execute  (stall_execute),
    .flush_if       (flush_if),
    .flush_id       (flush_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .redirect_count (redirect_count)
`ifdef REDIRECT_ALIGN_CHECK_EN
    ,
    .misalign_fault (misalign_fault),
    .fault_pc       (fault_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic [63:0] tgt, input logic [63:0] bpc);
    jump_target  = tgt;
    branch_pc    = bpc;
    execute_done = 1'b1;
    jump_signal  = 1'b1;
    step();
    execute_done = 1'b0;
    jump_signal  = 1'b0;
  endtask

  task automatic check_flush(input string tag);
    check({tag, "_flush_if"}, flush_if, 1);
    check({tag, "_flush_id"}, flush_id, 1);
    check({tag, "_stall"}, stall_execute, 1);
    check({tag, "_valid"}, redirect_valid, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stall"}, stall_execute, 0);
    check({tag, "_flush_if"}, flush_if, 0);
    check({tag, "_valid"}, redirect_valid, 0);
  endtask

  // Handshake monitor: every accepted redirect must match the oldest
  // expected entry, including the count value before it increments.
  always @(negedge clk) begin
    if (reset && redirect_valid && fetch_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect actual_pc=0x%0h required=none", redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_redirect_pc", redirect_pc, e.pc);
        check("sb_count_at_handshake", {32'd0, redirect_count}, {32'd0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    execute_done = 1'b0;
    jump_signal  = 1'b0;
    jump_target  = '0;
    branch_pc    = '0;
    fetch_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    check_idle("rst");
    check("rst_flush_id", flush_id, 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_count", redirect_count, 0);
    reset = 1'b1;
    step();

    // done without jump, and jump without done, are both ignored
    execute_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("nojump");
    end
    execute_done = 1'b0;
    jump_signal  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("nodone");
    end
    jump_signal = 1'b0;
    check("nojump_count", redirect_count, 0);

    // taken jump, fetch ready
    push_exp(64'h1000, 32'd0);
    launch(64'h1000, 64'h400);
    check_flush("j1_f0");
    for (int i = 1; i < FC; i++) begin
      step();
      check_flush("j1_fn");
    end
    step();
    check("j1_valid", redirect_valid, 1);
    check("j1_pc", redirect_pc, 64'h1000);
    check("j1_flush_if", flush_if, 0);
    check("j1_stall", stall_execute, 1);
    step();
    check("j1_resume_busy", busy, 1);
    check("j1_resume_stall", stall_execute, 0);
    check("j1_resume_valid", redirect_valid, 0);
    step();
    check_idle("j1_done");
    check("j1_count", redirect_count, 1);

    // backpressure: fetch not ready for 5 REDIRECT cycles
    fetch_ready = 1'b0;
    push_exp(64'h1000, 32'd1);
    launch(64'h1000, 64'h404);
    for (int i = 0; i < FC; i++) begin
      check_flush("bp_f");
      step();
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", redirect_valid, 1);
      check("bp_hold_pc", redirect_pc, 64'h1000);
      check("bp_hold_stall", stall_execute, 1);
      if (i < 4) step();
    end
    step();
    check("bp_still_valid", redirect_valid, 1);
    check("bp_count_held", redirect_count, 1);
    fetch_ready = 1'b1;
    step();
    check("bp_resume_stall", stall_execute, 0);
    check("bp_count", redirect_count, 2);
    step();
    check_idle("bp_done");

    // stale inputs held high; target changes after capture
    push_exp(64'h3000, 32'd2);
    push_exp(64'h4000, 32'd3);
    jump_target  = 64'h3000;
    execute_done = 1'b1;
    jump_signal  = 1'b1;
    step();
    jump_target = 64'h4000;
    for (int i = 0; i < FC; i++) begin
      check_flush("st1_f");
      step();
    end
    check("st1_valid", redirect_valid, 1);
    check("st1_pc", redirect_pc, 64'h3000);
    step();
    check("st1_resume_busy", busy, 1);
    check("st1_resume_stall", stall_execute, 0);
    check("st1_resume_flush", flush_if, 0);
    step();
    check_idle("st1_idle");
    check("st1_count", redirect_count, 3);
    step();
    check_flush("st2_f0");
    execute_done = 1'b0;
    jump_signal  = 1'b0;
    for (int i = 1; i < FC; i++) begin
      step();
      check_flush("st2_fn");
    end
    step();
    check("st2_pc", redirect_pc, 64'h4000);
    step();
    step();
    check_idle("st2_done");
    check("st2_count", redirect_count, 4);

    // asynchronous reset while a redirect is pending
    fetch_ready = 1'b0;
    launch(64'h5000, 64'h500);
    for (int i = 0; i < FC; i++) step();
    check("ar_valid_before", redirect_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_idle("ar_async");
    check("ar_flush_id", flush_id, 0);
    check("ar_pc", redirect_pc, 0);
    check("ar_count", redirect_count, 0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    fetch_ready = 1'b1;
    step();
    check_idle("ar_after");
    check("ar_after_count", redirect_count, 0);

    // normal jump after reset
    push_exp(64'h6000, 32'd0);
    launch(64'h6000, 64'h600);
    for (int i = 0; i < FC; i++) step();
    check("post_valid", redirect_valid, 1);
    step();
    step();
    check("post_count", redirect_count, 1);

`ifdef REDIRECT_ALIGN_CHECK_EN
    // misaligned target: flush, then fault pulse instead of redirect
    launch(64'h1002, 64'h800);
    for (int i = 0; i < FC; i++) begin
      check_flush("mis_f");
      check("mis_no_fault", misalign_fault, 0);
      step();
    end
    check("mis_valid", redirect_valid, 0);
    check("mis_fault", misalign_fault, 1);
    check("mis_fault_pc", fault_pc, 64'h800);
    step();
    check("mis_fault_pulse", misalign_fault, 0);
    check("mis_resume_busy", busy, 1);
    check("mis_resume_stall", stall_execute, 0);
    step();
    check_idle("mis_done");
    check("mis_count", redirect_count, 1);
`endif

    repeat (2) step();
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
